cat_frame_loader: RTL and testbench



---
 rtl/cat_pkg.sv | 21 ++
 rtl/cat_pixel_packer.sv | 37 +++
 rtl/cat_frame_loader.sv | 145 ++++++++++++++
 tb/tb_cat_frame_loader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cat_pkg.sv
// Shared types and constants for the cat recogniser frame loader.
// The state encoding keeps PACK at zero so the reset state is the all-zero vector.
package cat_pkg;

    localparam int PIXEL_WIDTH            = 8;
    localparam int PIXELS_PER_WORD        = 3;
    localparam int START_VALUE            = 1;
    localparam int DEFAULT_PIXEL_WORDS    = 4096;
    localparam int DEFAULT_COMPUTE_CYCLES = 4104;

    typedef enum logic [2:0] {
        PACK         = 3'd0,
        SETUP        = 3'd1,
        ACCESS       = 3'd2,
        START_SETUP  = 3'd3,
        START_ACCESS = 3'd4,
        WAIT         = 3'd5,
        DONE         = 3'd6
    } state_t;

endpackage

// File: rtl/cat_pixel_packer.sv
// Collects three pixel bytes into one 24-bit word, lowest lane first.
// o_word_ready strobes in the cycle the third byte is accepted.
module cat_pixel_packer
    import cat_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_clear,
    input  logic                                   i_accept,
    input  logic [PIXEL_WIDTH-1:0]                 i_data,
    output logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] o_word,
    output logic                                   o_word_ready
);

    localparam logic [1:0] LAST_BYTE = 2'(PIXELS_PER_WORD - 1);

    logic [1:0]                                 r_byte_cnt;
    logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0]     r_word;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_byte_cnt <= '0;
            r_word     <= '0;
        end else if (i_accept) begin
            case (r_byte_cnt)
                2'd0:    r_word[PIXEL_WIDTH-1:0]               <= i_data;
                2'd1:    r_word[2*PIXEL_WIDTH-1:PIXEL_WIDTH]   <= i_data;
                default: r_word[3*PIXEL_WIDTH-1:2*PIXEL_WIDTH] <= i_data;
            endcase
            r_byte_cnt <= (r_byte_cnt == LAST_BYTE) ? 2'd0 : r_byte_cnt + 2'd1;
        end
    end

    assign o_word       = r_word;
    assign o_word_ready = i_accept && (r_byte_cnt == LAST_BYTE);

endmodule

// File: rtl/cat_frame_loader.sv
// APB master feeding one packed pixel frame into the cat recogniser, triggering it,
// holding PSEL through its compute window and capturing the 1-bit verdict.
module cat_frame_loader
    import cat_pkg::*;
#(
    parameter int AMBA_WORD       = 24,
    parameter int AMBA_ADDR_DEPTH = 12,
    parameter int PIXEL_WORDS     = DEFAULT_PIXEL_WORDS,
    parameter int COMPUTE_CYCLES  = DEFAULT_COMPUTE_CYCLES,
    parameter int START_ADDR      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     px_valid,
    input  logic [PIXEL_WIDTH-1:0]   px_data,
    output logic                     px_ready,
    output logic                     PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [AMBA_ADDR_DEPTH:0] PADDR,
    output logic [AMBA_WORD-1:0]     PWDATA,
    input  logic                     cat_rec_in,
    output logic                     busy,
    output logic                     result_valid,
    output logic                     result
);

    localparam int ADDR_W = AMBA_ADDR_DEPTH + 1;
    localparam int WAIT_W = $clog2(COMPUTE_CYCLES);

    localparam logic [ADDR_W-1:0]    LAST_WORD  = ADDR_W'(PIXEL_WORDS - 1);
    localparam logic [WAIT_W-1:0]    LAST_WAIT  = WAIT_W'(COMPUTE_CYCLES - 1);
    localparam logic [ADDR_W-1:0]    START_PADR = ADDR_W'(START_ADDR);
    localparam logic [AMBA_WORD-1:0] START_WORD = AMBA_WORD'(START_VALUE);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_W-1:0]     r_word_cnt;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic                  r_started;
    logic                  r_result;
    logic                  r_result_valid;
    logic                  w_accept;
    logic                  w_clear;
    logic                  w_word_ready;
    logic                  w_wait_last;
    logic [AMBA_WORD-1:0]  w_word;

    assign w_accept    = px_valid && px_ready;
    assign w_clear     = (r_state == ACCESS);
    assign w_wait_last = (r_wait_cnt == LAST_WAIT);

    cat_pixel_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_accept     (w_accept),
        .i_data       (px_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PACK;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            PACK:         if (w_word_ready) w_next_state = SETUP;
            SETUP:        w_next_state = ACCESS;
            ACCESS:       w_next_state = (r_word_cnt == LAST_WORD) ? START_SETUP : PACK;
            START_SETUP:  w_next_state = START_ACCESS;
            START_ACCESS: w_next_state = WAIT;
            WAIT:         if (w_wait_last) w_next_state = DONE;
            DONE:         w_next_state = DONE;
            default:      w_next_state = PACK;
        endcase
    end

    // Once the first word is written PSEL stays high until DONE so the slave never sees a deselect.
    always_comb begin
        px_ready = 1'b0;
        PSEL     = 1'b0;
        PENABLE  = 1'b0;
        PWRITE   = 1'b0;
        PADDR    = '0;
        PWDATA   = '0;
        case (r_state)
            PACK: begin
                px_ready = 1'b1;
                PSEL     = (r_word_cnt != '0);
            end
            SETUP, ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = (r_state == ACCESS);
                PWRITE  = 1'b1;
                PADDR   = r_word_cnt + 1'b1;
                PWDATA  = w_word;
            end
            START_SETUP, START_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = (r_state == START_ACCESS);
                PWRITE  = 1'b1;
                PADDR   = START_PADR;
                PWDATA  = START_WORD;
            end
            WAIT:    PSEL = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt     <= '0;
            r_wait_cnt     <= '0;
            r_started      <= 1'b0;
            r_result       <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            if (r_state == ACCESS) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
            if (r_state == WAIT && !w_wait_last) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_accept) begin
                r_started <= 1'b1;
            end
            if (r_state == WAIT && w_wait_last) begin
                r_result       <= cat_rec_in;
                r_result_valid <= 1'b1;
            end
        end
    end

    assign busy         = r_started && (r_state != DONE);
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_cat_frame_loader.sv
// Randomised self-checking bench for cat_frame_loader; expected APB traffic is
// derived from the accepted byte stream, not from the loader's internal state.
module tb_cat_frame_loader;

    localparam int PIXEL_WORDS    = 4096;
    localparam int COMPUTE_CYCLES = 4104;
    localparam int FRAME_BYTES    = 3 * PIXEL_WORDS;

    logic        clk;
    logic        rst;
    logic        px_valid;
    logic [7:0]  px_data;
    logic        px_ready;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [12:0] PADDR;
    logic [23:0] PWDATA;
    logic        cat_rec_in;
    logic        busy;
    logic        result_valid;
    logic        result;

    int errors = 0;
    int checks = 0;

    logic [12:0] wrAddr[$];
    logic [23:0] wrData[$];
    logic [7:0]  sentBytes[$];
    int          waitCycles = 0;
    int          protoErrors = 0;
    int          earlySel = 0;
    bit          startSeen = 0;
    logic        prevSel = 0;
    logic        prevEn = 0;
    logic        prevWrite = 0;
    logic [12:0] prevAddr = '0;
    logic [23:0] prevData = '0;

    cat_frame_loader #(
        .AMBA_WORD       (24),
        .AMBA_ADDR_DEPTH (12),
        .PIXEL_WORDS     (PIXEL_WORDS),
        .COMPUTE_CYCLES  (COMPUTE_CYCLES),
        .START_ADDR      (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .px_valid     (px_valid),
        .px_data      (px_data),
        .px_ready     (px_ready),
        .PSEL         (PSEL),
        .PENABLE      (PENABLE),
        .PWRITE       (PWRITE),
        .PADDR        (PADDR),
        .PWDATA       (PWDATA),
        .cat_rec_in   (cat_rec_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // APB observer: records completed writes and checks each ACCESS follows a matching SETUP.
    always @(negedge clk) begin
        if (PSEL && PENABLE && PWRITE) begin
            wrAddr.push_back(PADDR);
            wrData.push_back(PWDATA);
            if (!(prevSel && !prevEn && prevWrite && prevAddr == PADDR && prevData == PWDATA))
                protoErrors++;
            if (PADDR == 13'd0) startSeen = 1'b1;
        end else if (startSeen && PSEL && !PENABLE && !PWRITE) begin
            waitCycles++;
        end
        if (PSEL && !PWRITE && wrAddr.size() == 0) earlySel++;
        prevSel   = PSEL;
        prevEn    = PENABLE;
        prevWrite = PWRITE;
        prevAddr  = PADDR;
        prevData  = PWDATA;
    end

    task automatic resetDut();
        @(negedge clk);
        rst      = 1'b1;
        px_valid = 1'b0;
        @(negedge clk);
        wrAddr.delete();
        wrData.delete();
        sentBytes.delete();
        waitCycles  = 0;
        protoErrors = 0;
        earlySel    = 0;
        startSeen   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input int nBytes, input int validPct, input bit randomData, input int maxCycles);
        int sent = 0;
        int cyc = 0;
        logic [7:0] b;
        while (sent < nBytes && cyc < maxCycles) begin
            @(negedge clk);
            cyc++;
            b = randomData ? 8'($urandom) : 8'(sent % 256);
            px_valid = ($urandom_range(99) < validPct);
            px_data  = px_valid ? b : 8'($urandom);
            if (px_valid && px_ready) begin
                sentBytes.push_back(b);
                sent++;
            end
        end
        checkOutput("stim_bytes_accepted", sent, nBytes);
    endtask

    task automatic waitResult(input int maxCycles);
        int n = 0;
        while (result_valid !== 1'b1 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("result_valid_seen", 32'(result_valid), 1);
    endtask

    task automatic checkFrame(input logic expResult);
        int badWords = 0;
        logic [23:0] expWord;
        checkOutput("frame_write_count", wrAddr.size(), PIXEL_WORDS + 1);
        for (int k = 0; k < PIXEL_WORDS; k++) begin
            if (3 * k + 2 >= sentBytes.size() || k >= wrAddr.size()) begin
                badWords++;
            end else begin
                expWord = {sentBytes[3*k+2], sentBytes[3*k+1], sentBytes[3*k]};
                if (wrAddr[k] !== 13'(k + 1) || wrData[k] !== expWord) badWords++;
            end
        end
        checkOutput("frame_bad_words", badWords, 0);
        if (wrAddr.size() > PIXEL_WORDS) begin
            checkOutput("start_addr", 32'(wrAddr[PIXEL_WORDS]), 0);
            checkOutput("start_data", 32'(wrData[PIXEL_WORDS]), 1);
        end else begin
            checkOutput("start_write_present", wrAddr.size(), PIXEL_WORDS + 1);
        end
        checkOutput("wait_psel_cycles", waitCycles, COMPUTE_CYCLES);
        checkOutput("apb_setup_access", protoErrors, 0);
        checkOutput("psel_before_first", earlySel, 0);
        checkOutput("result", 32'(result), 32'(expResult));
        checkOutput("done_result_valid", 32'(result_valid), 1);
        checkOutput("done_busy", 32'(busy), 0);
        checkOutput("done_psel", 32'(PSEL), 0);
    endtask

    task automatic testFirstWord();
        logic [7:0] bytesIn[3] = '{8'h11, 8'h22, 8'h33};
        resetDut();
        checkOutput("reset_psel", 32'(PSEL), 0);
        checkOutput("reset_penable", 32'(PENABLE), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_result_valid", 32'(result_valid), 0);
        checkOutput("reset_px_ready", 32'(px_ready), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("first_px_ready", 32'(px_ready), 1);
            px_valid = 1'b1;
            px_data  = bytesIn[i];
        end
        @(negedge clk);
        px_valid = 1'b0;
        checkOutput("setup_psel", 32'(PSEL), 1);
        checkOutput("setup_penable", 32'(PENABLE), 0);
        checkOutput("setup_pwrite", 32'(PWRITE), 1);
        checkOutput("setup_paddr", 32'(PADDR), 1);
        checkOutput("setup_pwdata", 32'(PWDATA), 32'h332211);
        checkOutput("setup_px_ready", 32'(px_ready), 0);
        checkOutput("setup_busy", 32'(busy), 1);
        @(negedge clk);
        checkOutput("access_penable", 32'(PENABLE), 1);
        checkOutput("access_paddr", 32'(PADDR), 1);
        checkOutput("access_pwdata", 32'(PWDATA), 32'h332211);
        checkOutput("access_px_ready", 32'(px_ready), 0);
        @(negedge clk);
        checkOutput("gap_px_ready", 32'(px_ready), 1);
        checkOutput("gap_psel_held", 32'(PSEL), 1);
        checkOutput("gap_penable", 32'(PENABLE), 0);
        checkOutput("gap_pwrite", 32'(PWRITE), 0);
    endtask

    task automatic testStall();
        logic       validPat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] bytesIn[3]  = '{8'hAA, 8'hBB, 8'hCC};
        int idx = 0;
        resetDut();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            px_valid = validPat[i];
            px_data  = validPat[i] ? bytesIn[idx] : 8'($urandom);
            if (validPat[i]) idx++;
        end
        @(negedge clk);
        px_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("stall_write_count", wrAddr.size(), 1);
        checkOutput("stall_paddr", (wrAddr.size() > 0) ? 32'(wrAddr[0]) : 32'hFFFF_FFFF, 1);
        checkOutput("stall_pwdata", (wrData.size() > 0) ? 32'(wrData[0]) : 32'hFFFF_FFFF, 32'hCCBBAA);
        checkOutput("stall_psel_early", earlySel, 0);
    endtask

    task automatic testMidReset();
        bit found = 1'b0;
        logic [23:0] expWord;
        resetDut();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (PSEL && PENABLE && PADDR == 13'd100) begin
                found = 1'b1;
                break;
            end
            px_valid = 1'b1;
            px_data  = 8'($urandom);
        end
        checkOutput("reach_word_100", 32'(found), 1);
        rst      = 1'b1;
        px_valid = 1'b0;
        @(negedge clk);
        checkOutput("midrst_psel", 32'(PSEL), 0);
        checkOutput("midrst_penable", 32'(PENABLE), 0);
        checkOutput("midrst_paddr", 32'(PADDR), 0);
        checkOutput("midrst_pwdata", 32'(PWDATA), 0);
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_px_ready", 32'(px_ready), 1);
        wrAddr.delete();
        wrData.delete();
        sentBytes.delete();
        rst = 1'b0;
        applyStimulus(3, 100, 1'b1, 50);
        @(negedge clk);
        px_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midrst_write_count", wrAddr.size(), 1);
        checkOutput("midrst_restart_paddr", (wrAddr.size() > 0) ? 32'(wrAddr[0]) : 32'hFFFF_FFFF, 1);
        expWord = (sentBytes.size() == 3) ? {sentBytes[2], sentBytes[1], sentBytes[0]} : 24'h0;
        checkOutput("midrst_restart_data", (wrData.size() > 0) ? 32'(wrData[0]) : 32'hFFFF_FFFF, 32'(expWord));
    endtask

    task automatic testDoneIdle();
        int readyHigh = 0;
        int apbActive = 0;
        int writesBefore;
        writesBefore = wrAddr.size();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            px_valid = 1'b1;
            px_data  = 8'($urandom);
            if (px_ready) readyHigh++;
            if (PSEL || PENABLE || PWRITE) apbActive++;
        end
        px_valid = 1'b0;
        checkOutput("done_px_ready_cycles", readyHigh, 0);
        checkOutput("done_apb_cycles", apbActive, 0);
        checkOutput("done_no_new_writes", wrAddr.size(), writesBefore);
        checkOutput("done_result_held", 32'(result_valid), 1);
    endtask

    initial begin
        rst        = 1'b1;
        px_valid   = 1'b0;
        px_data    = '0;
        cat_rec_in = 1'b0;

        testFirstWord();
        testStall();
        testMidReset();

        // Frame with index-valued bytes, random valid gaps and a positive verdict.
        resetDut();
        cat_rec_in = 1'b1;
        applyStimulus(FRAME_BYTES, 85, 1'b0, 40000);
        @(negedge clk);
        px_valid = 1'b0;
        checkOutput("frame1_busy", 32'(busy), 1);
        waitResult(6000);
        checkFrame(1'b1);
        testDoneIdle();

        // Same flow with random bytes, continuous valid and a negative verdict.
        resetDut();
        cat_rec_in = 1'b0;
        applyStimulus(FRAME_BYTES, 100, 1'b1, 30000);
        @(negedge clk);
        px_valid = 1'b0;
        waitResult(6000);
        checkFrame(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
